// File: rtl/qed_consistency_checker_if.sv
// Commit-side and register-file-port signals shared between the retire stage and the QED checker.
// The master drives commits, pipeline status and register read data; the checker drives addresses and status.
interface qed_consistency_checker_if;
    logic        commit_valid;
    logic        commit_is_dup;
    logic        pipe_empty;
    logic [4:0]  chk_addr_a;
    logic [4:0]  chk_addr_b;
    logic [31:0] chk_data_a;
    logic [31:0] chk_data_b;
    logic        qed_check_done;
    logic        qed_consistent;
    logic [4:0]  qed_mismatch_idx;
    logic        qed_cnt_sat;

    modport master (
        output commit_valid, commit_is_dup, pipe_empty, chk_data_a, chk_data_b,
        input  chk_addr_a, chk_addr_b, qed_check_done, qed_consistent,
               qed_mismatch_idx, qed_cnt_sat
    );

    modport slave (
        input  commit_valid, commit_is_dup, pipe_empty, chk_data_a, chk_data_b,
        output chk_addr_a, chk_addr_b, qed_check_done, qed_consistent,
               qed_mismatch_idx, qed_cnt_sat
    );
endinterface

// File: rtl/qed_consistency_checker.sv
// Retire-side QED checker: counts original/duplicate commits, scans r1..r15 against r17..r31 when balanced and drained.
// Done pulse 1+NUM_PAIRS cycles after entry; no backpressure -- any commit or non-empty pipe aborts a scan.
module qed_consistency_checker #(
    parameter int NUM_PAIRS  = 15,
    parameter int DUP_OFFSET = 16,
    parameter int CNT_W      = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    qed_consistency_checker_if.slave bus
);

    localparam logic [4:0]       LAST_IDX = 5'(NUM_PAIRS);
    localparam logic [4:0]       OFFSET   = 5'(DUP_OFFSET);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {IDLE, CHECK, REPORT} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt_orig, cnt_dup;
    logic [CNT_W-1:0] cnt_orig_nxt, cnt_dup_nxt;
    logic [4:0]       idx;
    logic             checked;
    logic             consistent;
    logic [4:0]       mismatch_idx;
    logic             cnt_sat;

    logic start_ok;
    logic abort;
    logic last_pair;
    logic pair_mismatch;

    always_comb begin
        cnt_orig_nxt = cnt_orig;
        cnt_dup_nxt  = cnt_dup;
        if (bus.commit_valid) begin
            if (bus.commit_is_dup) begin
                if (cnt_dup != CNT_MAX) cnt_dup_nxt = cnt_dup + 1'b1;
            end else begin
                if (cnt_orig != CNT_MAX) cnt_orig_nxt = cnt_orig + 1'b1;
            end
        end
    end

    assign start_ok      = (cnt_orig == cnt_dup) && (cnt_orig != '0) &&
                           bus.pipe_empty && !bus.commit_valid && !checked && !cnt_sat;
    assign abort         = bus.commit_valid || !bus.pipe_empty;
    assign last_pair     = (idx == LAST_IDX);
    assign pair_mismatch = (bus.chk_data_a != bus.chk_data_b);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = CHECK;
            CHECK: begin
                if (abort)          state_nxt = IDLE;
                else if (last_pair) state_nxt = REPORT;
            end
            REPORT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            cnt_orig     <= '0;
            cnt_dup      <= '0;
            idx          <= 5'd1;
            checked      <= 1'b0;
            consistent   <= 1'b1;
            mismatch_idx <= '0;
            cnt_sat      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt_orig <= cnt_orig_nxt;
            cnt_dup  <= cnt_dup_nxt;

            if ((cnt_orig_nxt == CNT_MAX) || (cnt_dup_nxt == CNT_MAX)) cnt_sat <= 1'b1;

            if (state == IDLE && start_ok)        idx <= 5'd1;
            else if (state == CHECK && !last_pair) idx <= idx + 5'd1;

            // A commit arriving in the report cycle changes the counts, so it must re-arm checking.
            if (bus.commit_valid)     checked <= 1'b0;
            else if (state == REPORT) checked <= 1'b1;

            if (state == CHECK && pair_mismatch && consistent) begin
                consistent   <= 1'b0;
                mismatch_idx <= idx;
            end
        end
    end

    assign bus.chk_addr_a       = (state == CHECK) ? idx : 5'd0;
    assign bus.chk_addr_b       = (state == CHECK) ? idx + OFFSET : 5'd0;
    assign bus.qed_check_done   = (state == REPORT);
    assign bus.qed_consistent   = consistent;
    assign bus.qed_mismatch_idx = mismatch_idx;
    assign bus.qed_cnt_sat      = cnt_sat;

endmodule

// File: doc/qed_consistency_checker.md
Name: qed_consistency_checker

Overview:
- Retire-side end of the QED flow; the fetch-side QED module is its producer.
- The fetch side injects a duplicate of each original instruction, remapping registers r1..r15 onto r17..r31.
- This block counts committed original and duplicate instructions. Whenever the two counts match and the pipeline is drained, it scans the register file and compares each original register with its duplicate.
- Any mismatch is reported as a sticky QED failure. The block sits beside writeback and uses two dedicated register-file read ports.

Parameters:
- NUM_PAIRS, 15, number of register pairs compared (r1..r15 against r17..r31)
- DUP_OFFSET, 16, address offset from an original register to its duplicate
- CNT_W, 16, width of the commit counters

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- commit_valid  input  1  an instruction retires this cycle
- commit_is_dup  input  1  the retiring instruction is a QED duplicate (qualified by commit_valid)
- pipe_empty  input  1  no instruction is in flight in IF..WB
- chk_addr_a  output  5  read address, original register
- chk_addr_b  output  5  read address, duplicate register (chk_addr_a + DUP_OFFSET)
- chk_data_a  input  32  combinational register-file data for chk_addr_a
- chk_data_b  input  32  combinational register-file data for chk_addr_b
- qed_check_done  output  1  one-cycle pulse when a scan completes
- qed_consistent  output  1  sticky; 0 once any mismatch has been seen
- qed_mismatch_idx  output  5  original-register index of the first mismatch
- qed_cnt_sat  output  1  a commit counter has saturated; checking is disabled

Behaviour:
- Reset values: cnt_orig=0, cnt_dup=0, state=IDLE, idx=1, checked=0, chk_addr_a=0, chk_addr_b=0, qed_check_done=0, qed_consistent=1, qed_mismatch_idx=0, qed_cnt_sat=0.
- Reset mid-scan aborts the scan and restores all reset values. No done pulse is issued.
- Counting: when commit_valid=1, increment cnt_dup if commit_is_dup=1, otherwise increment cnt_orig.
  - Counters saturate at all-ones.
  - qed_cnt_sat is set when either counter reaches all-ones and stays set until reset.
  - Any commit clears the checked flag.
- States: IDLE, CHECK, REPORT.
- IDLE -> CHECK when all of the following hold in the same cycle:
  - cnt_orig == cnt_dup and cnt_orig != 0
  - pipe_empty=1 and commit_valid=0
  - checked=0 and qed_cnt_sat=0
  - On entry, idx is loaded with 1.
- CHECK, each cycle:
  - Drive chk_addr_a=idx and chk_addr_b=idx+DUP_OFFSET.
  - Compare chk_data_a with chk_data_b combinationally in that same cycle.
  - Record the first mismatch only: qed_consistent<=0 and qed_mismatch_idx<=idx, but only while qed_consistent is still 1.
  - If idx==NUM_PAIRS, go to REPORT; otherwise idx<=idx+1.
  - The scan takes exactly NUM_PAIRS cycles.
- CHECK abort: if commit_valid=1 or pipe_empty=0 during CHECK, go to IDLE the next cycle.
  - No done pulse is issued and checked stays 0.
  - Mismatches already recorded earlier in the aborted scan are kept.
- REPORT: pulse qed_check_done=1 for one cycle, set checked=1, go to IDLE. Commits during REPORT are still counted.
- In IDLE and REPORT, chk_addr_a and chk_addr_b are driven to 0.
- A completed scan is not repeated until a further commit clears checked and the counts are equal again.
- Total latency from the entry condition first holding to qed_check_done: 1 (IDLE->CHECK) + NUM_PAIRS (CHECK) = 16 cycles. The pulse is asserted in the REPORT cycle.
- r0 and r16 are never compared.

Test Plan:
- Reset -> qed_consistent=1, qed_check_done=0, qed_cnt_sat=0, chk_addr_a=0, state IDLE.
- 3 original + 3 duplicate commits, register file with rN==r(N+16) for all N, pipe_empty=1 -> chk_addr_a steps 1..15 while chk_addr_b steps 17..31. qed_check_done pulses 16 cycles after the last commit-free cycle with the entry condition met; qed_consistent=1. No second scan follows without a new commit.
- Same setup with r5=7, r21=9 and r9=1, r25=2 -> qed_consistent=0, qed_mismatch_idx=5, done pulse still issued. A later all-equal scan leaves qed_consistent=0 and qed_mismatch_idx=5.
- 3 original + 2 duplicate commits, pipe idle -> no scan, chk_addr_a stays 0. One further duplicate commit -> scan starts the next eligible cycle.
- commit_valid=1 while chk_addr_a=8 -> state returns to IDLE, no done pulse. The scan restarts from idx 1 once the counts re-balance.
- reset asserted at chk_addr_a=10 -> all outputs return to reset values next cycle, counters at 0, no done pulse.
